// File: rtl/sound_latch.sv
// sound_latch: main<->sound CPU command/reply mailbox.
// Command writes raise a sound IRQ; reply latch is plain storage.
module sound_latch #(
  parameter int DW       = 16,
  parameter bit IRQ_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m68kp_latch0_cs,
  input  logic          m68kp_latch1_cs,
  input  logic          m68kp_as_n,
  input  logic          m68kp_rw,
  input  logic          m68kp_uds_n,
  input  logic          m68kp_lds_n,
  input  logic [DW-1:0] m68kp_din,
  output logic [DW-1:0] m68kp_dout,
  input  logic          m68ks_latch0_cs,
  input  logic          m68ks_latch1_cs,
  input  logic          m68ks_as_n,
  input  logic          m68ks_rw,
  input  logic          m68ks_uds_n,
  input  logic          m68ks_lds_n,
  input  logic [DW-1:0] m68ks_din,
  output logic [DW-1:0] m68ks_dout,
  input  logic          m68ks_iack,
  output logic          m68ks_irq,
  output logic          cmd_pending,
  output logic          cmd_overrun
);

  localparam int H = DW / 2;

  logic [DW-1:0] cmd_q;
  logic [DW-1:0] reply_q;

  // channel 0: main cmd, 1: sound cmd, 2: sound reply
  logic [2:0] acc;
  logic [2:0] acc_d;
  logic [2:0] armed;
  logic [2:0] start;
  logic [2:0] stop;
  logic       s_rd_q;

  logic p_strb;
  logic s_strb;
  logic wr_cmd;
  logic rd_cmd_end;
  logic wr_reply;

  // main side only reads the reply latch, which has no side effects
  logic unused_ok;
  assign unused_ok = m68kp_latch1_cs;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] din,
    input logic          uds_n,
    input logic          lds_n
  );
    merge = old;
    if (!uds_n) merge[DW-1:H] = din[DW-1:H];
    if (!lds_n) merge[H-1:0] = din[H-1:0];
  endfunction

  assign p_strb = ~m68kp_uds_n | ~m68kp_lds_n;
  assign s_strb = ~m68ks_uds_n | ~m68ks_lds_n;

  assign acc[0] = m68kp_latch0_cs & ~m68kp_as_n & p_strb;
  assign acc[1] = m68ks_latch0_cs & ~m68ks_as_n & s_strb;
  assign acc[2] = m68ks_latch1_cs & ~m68ks_as_n & s_strb;

  // armed stays low after reset until the bus goes idle once
  assign start = acc & ~acc_d & armed;
  assign stop  = ~acc & acc_d;

  assign wr_cmd     = start[0] & ~m68kp_rw;
  assign rd_cmd_end = stop[1] & s_rd_q;
  assign wr_reply   = start[2] & ~m68ks_rw;

  assign m68kp_dout = reply_q;
  assign m68ks_dout = cmd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_d       <= '0;
      armed       <= '0;
      s_rd_q      <= 1'b0;
      cmd_q       <= '0;
      reply_q     <= '0;
      cmd_pending <= 1'b0;
      cmd_overrun <= 1'b0;
      m68ks_irq   <= 1'b0;
    end else begin
      armed <= armed | ~acc;
      acc_d <= acc & armed;
      if (start[1]) s_rd_q <= m68ks_rw;

      if (wr_cmd)
        cmd_q <= merge(cmd_q, m68kp_din,
                       m68kp_uds_n, m68kp_lds_n);
      if (wr_reply)
        reply_q <= merge(reply_q, m68ks_din,
                         m68ks_uds_n, m68ks_lds_n);

      // a read ending on the same edge clears the old command first
      if (wr_cmd) begin
        cmd_pending <= 1'b1;
        if (cmd_pending && !rd_cmd_end)
          cmd_overrun <= 1'b1;
      end else if (rd_cmd_end) begin
        cmd_pending <= 1'b0;
      end

      if (wr_cmd)
        m68ks_irq <= 1'b1;
      else if (!IRQ_HOLD)
        m68ks_irq <= 1'b0;
      else if (rd_cmd_end || m68ks_iack)
        m68ks_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_latch.sv
// tb_sound_latch: directed + random mailbox test against a
// transaction-level model of the latches and flags.
module tb_sound_latch;

  logic        clk;
  logic        reset;
  logic        m68kp_latch0_cs;
  logic        m68kp_latch1_cs;
  logic        m68kp_as_n;
  logic        m68kp_rw;
  logic        m68kp_uds_n;
  logic        m68kp_lds_n;
  logic [15:0] m68kp_din;
  logic [15:0] m68kp_dout;
  logic        m68ks_latch0_cs;
  logic        m68ks_latch1_cs;
  logic        m68ks_as_n;
  logic        m68ks_rw;
  logic        m68ks_uds_n;
  logic        m68ks_lds_n;
  logic [15:0] m68ks_din;
  logic [15:0] m68ks_dout;
  logic        m68ks_iack;
  logic        m68ks_irq;
  logic        cmd_pending;
  logic        cmd_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] cmd_m;
  logic [15:0] reply_m;
  logic        pend_m;
  logic        ovr_m;
  logic        irq_m;

  sound_latch dut (
    .clk             (clk),
    .reset           (reset),
    .m68kp_latch0_cs (m68kp_latch0_cs),
    .m68kp_latch1_cs (m68kp_latch1_cs),
    .m68kp_as_n      (m68kp_as_n),
    .m68kp_rw        (m68kp_rw),
    .m68kp_uds_n     (m68kp_uds_n),
    .m68kp_lds_n     (m68kp_lds_n),
    .m68kp_din       (m68kp_din),
    .m68kp_dout      (m68kp_dout),
    .m68ks_latch0_cs (m68ks_latch0_cs),
    .m68ks_latch1_cs (m68ks_latch1_cs),
    .m68ks_as_n      (m68ks_as_n),
    .m68ks_rw        (m68ks_rw),
    .m68ks_uds_n     (m68ks_uds_n),
    .m68ks_lds_n     (m68ks_lds_n),
    .m68ks_din       (m68ks_din),
    .m68ks_dout      (m68ks_dout),
    .m68ks_iack      (m68ks_iack),
    .m68ks_irq       (m68ks_irq),
    .cmd_pending     (cmd_pending),
    .cmd_overrun     (cmd_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic u_n,
                                        input logic l_n);
    logic [15:0] r;
    r = old;
    if (!u_n) r[15:8] = d[15:8];
    if (!l_n) r[7:0] = d[7:0];
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".cmd"}, m68ks_dout, cmd_m);
    check({tag, ".reply"}, m68kp_dout, reply_m);
    check({tag, ".irq"}, 16'(m68ks_irq), 16'(irq_m));
    check({tag, ".pend"}, 16'(cmd_pending), 16'(pend_m));
    check({tag, ".ovr"}, 16'(cmd_overrun), 16'(ovr_m));
  endtask

  task automatic model_reset();
    cmd_m = '0; reply_m = '0;
    pend_m = 0; ovr_m = 0; irq_m = 0;
  endtask

  task automatic p_idle();
    m68kp_latch0_cs = 0; m68kp_latch1_cs = 0;
    m68kp_as_n = 1; m68kp_rw = 1;
    m68kp_uds_n = 1; m68kp_lds_n = 1;
  endtask

  task automatic s_idle();
    m68ks_latch0_cs = 0; m68ks_latch1_cs = 0;
    m68ks_as_n = 1; m68ks_rw = 1;
    m68ks_uds_n = 1; m68ks_lds_n = 1;
  endtask

  task automatic p_cmd_drive(input logic [15:0] d,
                             input logic u_n,
                             input logic l_n);
    m68kp_latch0_cs = 1; m68kp_as_n = 0; m68kp_rw = 0;
    m68kp_uds_n = u_n; m68kp_lds_n = l_n; m68kp_din = d;
    if (pend_m) ovr_m = 1;
    cmd_m = lanes(cmd_m, d, u_n, l_n);
    pend_m = 1; irq_m = 1;
  endtask

  task automatic main_wr(input logic [15:0] d,
                         input logic u_n,
                         input logic l_n,
                         input int hold);
    @(negedge clk);
    p_cmd_drive(d, u_n, l_n);
    @(negedge clk);
    check_state("mwr");
    for (int i = 1; i < hold; i++) begin
      m68kp_din = 16'($urandom);
      @(negedge clk);
    end
    p_idle();
  endtask

  task automatic main_wr_ign(input int mode);
    @(negedge clk);
    m68kp_latch0_cs = (mode != 0);
    m68kp_as_n = (mode == 1);
    m68kp_rw = 0;
    m68kp_uds_n = (mode == 2) ? 1'b1 : 1'b0;
    m68kp_lds_n = (mode == 2) ? 1'b1 : 1'b0;
    m68kp_din = 16'($urandom);
    repeat (2) @(negedge clk);
    p_idle();
  endtask

  task automatic sound_rd(input int hold);
    @(negedge clk);
    m68ks_latch0_cs = 1; m68ks_as_n = 0; m68ks_rw = 1;
    m68ks_uds_n = 0; m68ks_lds_n = 0;
    repeat (hold) begin
      @(negedge clk);
      check_state("srd");
    end
    s_idle();
    pend_m = 0; irq_m = 0;
  endtask

  task automatic sound_wr(input logic [15:0] d,
                          input logic u_n,
                          input logic l_n,
                          input int hold);
    @(negedge clk);
    m68ks_latch1_cs = 1; m68ks_as_n = 0; m68ks_rw = 0;
    m68ks_uds_n = u_n; m68ks_lds_n = l_n; m68ks_din = d;
    reply_m = lanes(reply_m, d, u_n, l_n);
    @(negedge clk);
    check_state("swr");
    for (int i = 1; i < hold; i++) begin
      m68ks_din = 16'($urandom);
      @(negedge clk);
    end
    s_idle();
  endtask

  task automatic main_rd(input int hold);
    @(negedge clk);
    m68kp_latch1_cs = 1; m68kp_as_n = 0; m68kp_rw = 1;
    m68kp_uds_n = 0; m68kp_lds_n = 0;
    repeat (hold) begin
      @(negedge clk);
      check("mrd.dout", m68kp_dout, reply_m);
    end
    p_idle();
  endtask

  task automatic iack_pulse();
    @(negedge clk);
    m68ks_iack = 1;
    @(negedge clk);
    m68ks_iack = 0;
    irq_m = 0;
  endtask

  task automatic strobes(output logic u_n, output logic l_n);
    case ($urandom_range(0, 2))
      0: begin u_n = 0; l_n = 0; end
      1: begin u_n = 0; l_n = 1; end
      default: begin u_n = 1; l_n = 0; end
    endcase
  endtask

  initial begin
    logic u, l;
    reset = 1; m68ks_iack = 0;
    m68kp_din = '0; m68ks_din = '0;
    p_idle(); s_idle(); model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    check_state("reset");

    main_wr(16'h12A5, 0, 0, 5);
    @(negedge clk);
    check_state("word");
    sound_rd(2);
    @(negedge clk);
    check_state("word_rd");

    main_wr(16'h003C, 1, 0, 1);
    @(negedge clk);
    check("lds", m68ks_dout, 16'h123C);
    sound_rd(1);
    main_wr(16'h7700, 0, 1, 2);
    @(negedge clk);
    check("uds", m68ks_dout, 16'h773C);
    sound_rd(1);

    main_wr(16'h1111, 0, 0, 1);
    @(negedge clk);
    m68ks_latch0_cs = 1; m68ks_as_n = 0; m68ks_rw = 1;
    m68ks_uds_n = 0; m68ks_lds_n = 0;
    @(negedge clk);
    s_idle();
    pend_m = 0;
    p_cmd_drive(16'h2222, 0, 0);
    @(negedge clk);
    check_state("same_edge");
    p_idle();
    iack_pulse();
    @(negedge clk);
    check_state("iack");
    check("iack.pend", 16'(cmd_pending), 16'd1);
    sound_rd(1);

    sound_wr(16'h1357, 0, 0, 1);
    @(negedge clk);
    m68kp_latch1_cs = 1; m68kp_as_n = 0; m68kp_rw = 1;
    m68kp_uds_n = 0; m68kp_lds_n = 0;
    @(negedge clk);
    m68ks_latch1_cs = 1; m68ks_as_n = 0; m68ks_rw = 0;
    m68ks_uds_n = 0; m68ks_lds_n = 0; m68ks_din = 16'hBEEF;
    #1;
    check("conc.old", m68kp_dout, 16'h1357);
    @(posedge clk);
    #1;
    check("conc.new", m68kp_dout, 16'hBEEF);
    reply_m = 16'hBEEF;
    @(negedge clk);
    p_idle(); s_idle();

    main_wr(16'h0001, 0, 0, 1);
    main_wr(16'h0002, 0, 0, 1);
    @(negedge clk);
    check_state("ovr");
    check("ovr.dout", m68ks_dout, 16'h0002);
    sound_rd(1);
    @(negedge clk);
    check_state("ovr_rd");

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: begin
          strobes(u, l);
          main_wr(16'($urandom), u, l, $urandom_range(1, 4));
        end
        1: sound_rd($urandom_range(1, 3));
        2: iack_pulse();
        3: begin
          strobes(u, l);
          sound_wr(16'($urandom), u, l, $urandom_range(1, 3));
        end
        4: main_rd($urandom_range(1, 3));
        default: main_wr_ign($urandom_range(0, 2));
      endcase
      @(negedge clk);
      check_state("rnd");
    end

    @(negedge clk);
    m68ks_latch1_cs = 1; m68ks_as_n = 0; m68ks_rw = 0;
    m68ks_uds_n = 0; m68ks_lds_n = 0; m68ks_din = 16'hC0DE;
    reply_m = 16'hC0DE;
    @(negedge clk);
    check("rst.pre", m68kp_dout, 16'hC0DE);
    #2 reset = 1;
    #1;
    model_reset();
    check_state("rst.async");
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    check_state("rst.held");
    s_idle();
    repeat (2) @(negedge clk);
    main_wr(16'h5A5A, 0, 0, 2);
    @(negedge clk);
    check_state("rst.after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
